fetch_pc_ctrl: RTL

//  Fetch-stage PC controller for the Y86-64 pipeline; sits directly upstream of the

---
 rtl/fetch_pc_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC controller: selects the fetch PC, holds the F predicted-PC register
// and bubbles fetch while waiting for a ret target or sitting on a halt.
module fetch_pc_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [3:0]  IC_HALT  = 4'h0,
  parameter logic [3:0]  IC_JXX   = 4'h7,
  parameter logic [3:0]  IC_CALL  = 4'h8,
  parameter logic [3:0]  IC_RET   = 4'h9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  f_icode,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [3:0]  M_icode,
  input  logic        M_cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic        F_stall,
  output logic [63:0] f_pc,
  output logic [63:0] F_predPC,
  output logic        f_bubble,
  output logic [1:0]  f_state
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_RET_WAIT = 2'd1;
  localparam logic [1:0] S_HALTED   = 2'd2;

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [63:0] next_pc;
  logic        w_ret;
  logic        m_mispred;
  logic        correction;
  logic        active;
  logic        load;

  assign w_ret     = (W_icode == IC_RET);
  assign m_mispred = (M_icode == IC_JXX) && !M_cnd;

  // W ret outranks an M mispredict when both arrive together.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    f_pc = F_predPC;
    if (w_ret)          f_pc = W_valM;
    else if (m_mispred) f_pc = M_valA;
  end

  always_comb begin
    next_pc = f_valP;
    if (f_icode == IC_JXX || f_icode == IC_CALL) next_pc = f_valC;
    else if (f_icode == IC_HALT)                 next_pc = f_pc;
  end

  always_comb begin
    next_state = S_RUN;
    if (f_icode == IC_RET)       next_state = S_RET_WAIT;
    else if (f_icode == IC_HALT) next_state = S_HALTED;
  end

  // A correction is the redirect that releases a waiting state; it is consumed even
  // under stall, so it always loads the register.
  always_comb begin
    correction = 1'b0;
    case (state)
      S_RET_WAIT: correction = w_ret;
      S_HALTED:   correction = !w_ret && m_mispred;
      default:    correction = 1'b0;
    endcase
  end

  // The unused encoding behaves as RUN so the FSM can never lock up.
  assign active   = (state != S_RET_WAIT && state != S_HALTED) || correction;
  assign load     = active && (correction || !F_stall);
  assign f_bubble = !active;
  assign f_state  = state;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      F_predPC <= RESET_PC;
      state    <= S_RUN;
    end else if (load) begin
      F_predPC <= next_pc;
      state    <= next_state;
    end
  end

endmodule
